// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU: op-code values,
// FSM state encoding and the default op-code width.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL  = 4'd10;

    // Controller states; MUL is only reachable when the multiplier is built.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// Bit 0 of b is consumed on the start edge, then one further bit per cycle;
// done is raised in the cycle that consumes the last bit, with the final
// product presented combinationally on product in that same cycle.
module alu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  a_sh;
    logic [XLEN-1:0]  b_sh;
    logic [XLEN-1:0]  partial;

    assign partial = b_sh[0] ? a_sh : '0;
    assign product = acc + partial;
    assign done    = busy && (count == CNT_LAST);

    // Accumulate one shifted partial product per cycle until the last bit is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CNT_W'(1);
            acc   <= b[0] ? a : '0;
            a_sh  <= a << 1;
            b_sh  <= b >> 1;
        end else if (busy) begin
            acc   <= product;
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            if (count == CNT_LAST) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready on both sides. Single-cycle
// ops present their result one cycle after accept, with full throughput.
// Optional feature macro: ALU_MUL_EN adds op 10 (MUL) through an iterative
// multiplier; without it op 10 is reported as illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int OP_W      = ALU_OP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [OP_W-1:0]      i_alu_op,
    input  logic [XLEN-1:0]      i_alu_rs1,
    input  logic [XLEN-1:0]      i_alu_rs2,
    input  logic [REG_IDX_W-1:0] i_alu_rd_idx,
    input  logic                 i_alu_rd_wen,
    output logic                 o_alu_valid,
    input  logic                 i_alu_out_ready,
    output logic [XLEN-1:0]      o_alu_wdat,
    output logic [REG_IDX_W-1:0] o_alu_rd_idx,
    output logic                 o_alu_rd_wen,
    output logic                 o_alu_illegal
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0]    alu_res;
    logic               op_legal;
    logic               op_is_mul;
    logic               fsm_idle;
    logic               accept;
    logic               rd_wen_eff;
    logic [SHAMT_W-1:0] shamt;

    assign shamt       = i_alu_rs2[SHAMT_W-1:0];
    assign o_alu_ready = fsm_idle && (!o_alu_valid || i_alu_out_ready);
    assign accept      = i_alu_valid && o_alu_ready;
    assign rd_wen_eff  = i_alu_rd_wen && (i_alu_rd_idx != '0);

    // Single-cycle datapath; anything not decoded here is flagged illegal.
    always_comb begin
        alu_res  = '0;
        op_legal = 1'b1;
        case (i_alu_op)
            ALU_OP_ADD:  alu_res = i_alu_rs1 + i_alu_rs2;
            ALU_OP_SUB:  alu_res = i_alu_rs1 - i_alu_rs2;
            ALU_OP_AND:  alu_res = i_alu_rs1 & i_alu_rs2;
            ALU_OP_OR:   alu_res = i_alu_rs1 | i_alu_rs2;
            ALU_OP_XOR:  alu_res = i_alu_rs1 ^ i_alu_rs2;
            ALU_OP_SLL:  alu_res = i_alu_rs1 << shamt;
            ALU_OP_SRL:  alu_res = i_alu_rs1 >> shamt;
            ALU_OP_SRA:  alu_res = $unsigned($signed(i_alu_rs1) >>> shamt);
            ALU_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_alu_rs1) < $signed(i_alu_rs2))};
            ALU_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (i_alu_rs1 < i_alu_rs2)};
`ifdef ALU_MUL_EN
            ALU_OP_MUL:  alu_res = '0;
`endif
            default:     op_legal = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [0:0]           state;
    logic                 mul_start;
    logic                 mul_done;
    logic [XLEN-1:0]      mul_product;
    logic [REG_IDX_W-1:0] mul_rd_idx;
    logic                 mul_rd_wen;

    assign op_is_mul = (i_alu_op == ALU_OP_MUL);
    assign fsm_idle  = (state == ST_IDLE);
    assign mul_start = accept && op_is_mul;

    // Controller: sit in MUL from accept until the multiplier consumes its last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mul_start) state <= ST_MUL;
                ST_MUL:  if (mul_done)  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Destination info for a multiply is captured at accept and replayed on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_rd_idx <= '0;
            mul_rd_wen <= 1'b0;
        end else if (mul_start) begin
            mul_rd_idx <= i_alu_rd_idx;
            mul_rd_wen <= rd_wen_eff;
        end
    end

    alu_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (i_alu_rs1),
        .b      (i_alu_rs2),
        .done   (mul_done),
        .product(mul_product)
    );
`else
    assign op_is_mul = 1'b0;
    assign fsm_idle  = 1'b1;
`endif

    // Output register: load on accept or multiply completion, drop valid on transfer, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_alu_valid   <= 1'b0;
            o_alu_wdat    <= '0;
            o_alu_rd_idx  <= '0;
            o_alu_rd_wen  <= 1'b0;
            o_alu_illegal <= 1'b0;
        end else if (accept && !op_is_mul) begin
            o_alu_valid   <= 1'b1;
            o_alu_wdat    <= op_legal ? alu_res : '0;
            o_alu_rd_idx  <= i_alu_rd_idx;
            o_alu_rd_wen  <= rd_wen_eff && op_legal;
            o_alu_illegal <= !op_legal;
`ifdef ALU_MUL_EN
        end else if (mul_start) begin
            o_alu_valid   <= 1'b0;
        end else if (mul_done) begin
            o_alu_valid   <= 1'b1;
            o_alu_wdat    <= mul_product;
            o_alu_rd_idx  <= mul_rd_idx;
            o_alu_rd_wen  <= mul_rd_wen;
            o_alu_illegal <= 1'b0;
`endif
        end else if (o_alu_valid && i_alu_out_ready) begin
            o_alu_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (default XLEN=32). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [3:0]  i_alu_op;
    logic [31:0] i_alu_rs1;
    logic [31:0] i_alu_rs2;
    logic [4:0]  i_alu_rd_idx;
    logic        i_alu_rd_wen;
    logic        o_alu_valid;
    logic        i_alu_out_ready;
    logic [31:0] o_alu_wdat;
    logic [4:0]  o_alu_rd_idx;
    logic        o_alu_rd_wen;
    logic        o_alu_illegal;

    int checks;
    int errors;

    alu_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .i_alu_valid    (i_alu_valid),
        .o_alu_ready    (o_alu_ready),
        .i_alu_op       (i_alu_op),
        .i_alu_rs1      (i_alu_rs1),
        .i_alu_rs2      (i_alu_rs2),
        .i_alu_rd_idx   (i_alu_rd_idx),
        .i_alu_rd_wen   (i_alu_rd_wen),
        .o_alu_valid    (o_alu_valid),
        .i_alu_out_ready(i_alu_out_ready),
        .o_alu_wdat     (o_alu_wdat),
        .o_alu_rd_idx   (o_alu_rd_idx),
        .o_alu_rd_wen   (o_alu_rd_wen),
        .o_alu_illegal  (o_alu_illegal)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [4:0] rd,
                                 input logic wen);
        i_alu_valid  = 1'b1;
        i_alu_op     = op;
        i_alu_rs1    = rs1;
        i_alu_rs2    = rs2;
        i_alu_rd_idx = rd;
        i_alu_rd_wen = wen;
    endtask

    task automatic test_reset();
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal, o_alu_ready} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_initial got v=%b w=%h rd=%0d wen=%b ill=%b rdy=%b want 0 0 0 0 0 1",
                     o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal, o_alu_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        // Leave a result pending, then reset asynchronously mid-cycle.
        i_alu_out_ready = 1'b0;
        applyStimulus(4'd0, 32'd9, 32'd4, 5'd6, 1'b1);
        @(negedge clk);
        i_alu_valid = 1'b0;
        checks++;
        if (o_alu_valid !== 1'b1 || o_alu_wdat !== 32'd13) begin
            errors++;
            $display("[TB] FAIL reset_pending_setup got v=%b w=%h want v=1 w=0000000d", o_alu_valid, o_alu_wdat);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal, o_alu_ready} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_async got v=%b w=%h rd=%0d wen=%b ill=%b rdy=%b want 0 0 0 0 0 1",
                     o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal, o_alu_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        i_alu_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_wrap();
        applyStimulus(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b1);
        @(negedge clk);
        i_alu_valid = 1'b0;
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal} !== {1'b1, 32'h0, 5'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_wrap got v=%b w=%h rd=%0d wen=%b ill=%b want 1 00000000 3 1 0",
                     o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal);
        end
        @(negedge clk);
        checks++;
        if (o_alu_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_drain got v=%b want 0", o_alu_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [8];
        logic [31:0] a   [8];
        logic [31:0] b   [8];
        logic [31:0] exp [8];
        ops[0] = 4'd7; a[0] = 32'h8000_0000; b[0] = 32'h0000_0024; exp[0] = 32'hF800_0000;
        ops[1] = 4'd8; a[1] = 32'hFFFF_FFFF; b[1] = 32'h0000_0001; exp[1] = 32'h0000_0001;
        ops[2] = 4'd2; a[2] = 32'hF0F0_F0F0; b[2] = 32'h0FF0_0FF0; exp[2] = 32'h00F0_00F0;
        ops[3] = 4'd3; a[3] = 32'hF0F0_F0F0; b[3] = 32'h0FF0_0FF0; exp[3] = 32'hFFF0_FFF0;
        ops[4] = 4'd4; a[4] = 32'hF0F0_F0F0; b[4] = 32'h0FF0_0FF0; exp[4] = 32'hFF00_FF00;
        ops[5] = 4'd5; a[5] = 32'h0000_0001; b[5] = 32'hFFFF_FFFF; exp[5] = 32'h8000_0000;
        ops[6] = 4'd6; a[6] = 32'h8000_0000; b[6] = 32'h0000_003F; exp[6] = 32'h0000_0001;
        ops[7] = 4'd9; a[7] = 32'h0000_0001; b[7] = 32'hFFFF_FFFF; exp[7] = 32'h0000_0001;
        applyStimulus(ops[0], a[0], b[0], 5'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 7) applyStimulus(ops[i+1], a[i+1], b[i+1], 5'd1, 1'b1);
            else i_alu_valid = 1'b0;
            checks++;
            if (o_alu_valid !== 1'b1 || o_alu_wdat !== exp[i] || o_alu_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_op%0d got v=%b w=%h rdy=%b want v=1 w=%h rdy=1",
                         i, o_alu_valid, o_alu_wdat, o_alu_ready, exp[i]);
            end
        end
        // SLT with a positive rs1 above a negative rs2 must be 0.
        applyStimulus(4'd8, 32'h0000_0001, 32'hFFFF_FFFF, 5'd1, 1'b1);
        @(negedge clk);
        i_alu_valid = 1'b0;
        checks++;
        if (o_alu_wdat !== 32'h0) begin
            errors++;
            $display("[TB] FAIL slt_signed got w=%h want 00000000", o_alu_wdat);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        i_alu_out_ready = 1'b0;
        applyStimulus(4'd1, 32'd5, 32'd7, 5'd9, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 32'd100, 32'd200, 5'd2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_ready} !== {1'b1, 32'hFFFF_FFFE, 5'd9, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got v=%b w=%h rd=%0d wen=%b rdy=%b want 1 fffffffe 9 1 0",
                         c, o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_ready);
            end
            if (c < 2) @(negedge clk);
        end
        i_alu_valid = 1'b0;
        i_alu_out_ready = 1'b1;
        #1;
        checks++;
        if (o_alu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready got rdy=%b want 1", o_alu_ready);
        end
        @(negedge clk);
        checks++;
        if (o_alu_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_transfer got v=%b want 0", o_alu_valid);
        end
    endtask

    task automatic test_illegal_x0();
        applyStimulus(4'd13, 32'h1234_5678, 32'h1, 5'd0, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 32'd2, 32'd3, 5'd0, 1'b1);
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_wen, o_alu_illegal} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL illegal_op13 got v=%b w=%h wen=%b ill=%b want 1 00000000 0 1",
                     o_alu_valid, o_alu_wdat, o_alu_rd_wen, o_alu_illegal);
        end
        @(negedge clk);
        i_alu_valid = 1'b0;
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_wen, o_alu_illegal} !== {1'b1, 32'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL x0_add got v=%b w=%h wen=%b ill=%b want 1 00000005 0 0",
                     o_alu_valid, o_alu_wdat, o_alu_rd_wen, o_alu_illegal);
        end
        @(negedge clk);
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        int bad_ready;
        int saw_valid;
        bad_ready = 0;
        applyStimulus(4'd10, 32'h0001_0003, 32'h0000_0005, 5'd4, 1'b1);
        @(negedge clk);
        i_alu_valid = 1'b0;
        for (int k = 1; k < 32; k++) begin
            if (o_alu_ready !== 1'b0 || o_alu_valid !== 1'b0) bad_ready++;
            @(negedge clk);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("[TB] FAIL mul_busy got %0d cycles with ready/valid high want 0", bad_ready);
        end
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal} !== {1'b1, 32'h0005_000F, 5'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mul_result got v=%b w=%h rd=%0d wen=%b ill=%b want 1 0005000f 4 1 0",
                     o_alu_valid, o_alu_wdat, o_alu_rd_idx, o_alu_rd_wen, o_alu_illegal);
        end
        @(negedge clk);
        // Rerun, resetting at cycle N+10: nothing may come out.
        applyStimulus(4'd10, 32'h0001_0003, 32'h0000_0005, 5'd4, 1'b1);
        @(negedge clk);
        i_alu_valid = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_alu_valid !== 1'b0) saw_valid++;
            @(negedge clk);
        end
        checks++;
        if (saw_valid != 0 || o_alu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mul_reset got %0d valid cycles rdy=%b want 0 and rdy=1", saw_valid, o_alu_ready);
        end
    endtask
`else
    task automatic test_mul();
        applyStimulus(4'd10, 32'h0001_0003, 32'h0000_0005, 5'd4, 1'b1);
        @(negedge clk);
        i_alu_valid = 1'b0;
        checks++;
        if ({o_alu_valid, o_alu_wdat, o_alu_rd_wen, o_alu_illegal, o_alu_ready} !== {1'b1, 32'h0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mul_disabled got v=%b w=%h wen=%b ill=%b rdy=%b want 1 00000000 0 1 1",
                     o_alu_valid, o_alu_wdat, o_alu_rd_wen, o_alu_illegal, o_alu_ready);
        end
        @(negedge clk);
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        i_alu_valid     = 1'b0;
        i_alu_op        = 4'd0;
        i_alu_rs1       = 32'd0;
        i_alu_rs2       = 32'd0;
        i_alu_rd_idx    = 5'd0;
        i_alu_rd_wen    = 1'b0;
        i_alu_out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_stall();
        test_illegal_x0();
        test_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
